// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x oversampled UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int OS_TICKS = 16;
  localparam int MID_TICK = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for asynchronous inputs, with a configurable reset value.
module uart_rx_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver, 16x oversampled, mid-bit sampling, registered byte plus error flags.
// Optional parity stage is enabled by defining UART_RX_PARITY_EN.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter bit PAR_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err
);

`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_t DATA_EXIT  = PARITY;
  localparam bit             HAS_PARITY = 1'b1;
`else
  localparam uart_rx_state_t DATA_EXIT  = STOP;
  localparam bit             HAS_PARITY = 1'b0;
`endif

  localparam logic [4:0] S_MID  = 5'(MID_TICK);
  localparam logic [4:0] S_LAST = 5'(OS_TICKS - 1);
  localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST = 3'(DBIT - 1);

  uart_rx_state_t  state_reg, state_next;
  logic [4:0]      s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            perr_reg, perr_next;
  logic [7:0]      dout_reg, dout_next;
  logic            done_reg, done_next;
  logic            ferr_reg, ferr_next;
  logic            perr_out_reg, perr_out_next;
  logic            rx_s;

  uart_rx_sync #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (rx),
    .q      (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      perr_reg     <= 1'b0;
      dout_reg     <= '0;
      done_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      perr_out_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s_reg        <= s_next;
      n_reg        <= n_next;
      b_reg        <= b_next;
      perr_reg     <= perr_next;
      dout_reg     <= dout_next;
      done_reg     <= done_next;
      ferr_reg     <= ferr_next;
      perr_out_reg <= perr_out_next;
    end
  end

  // Start detection in IDLE is free-running; every other state only moves on s_tick.
  always_comb begin
    state_next    = state_reg;
    s_next        = s_reg;
    n_next        = n_reg;
    b_next        = b_reg;
    perr_next     = perr_reg;
    dout_next     = dout_reg;
    done_next     = 1'b0;
    ferr_next     = ferr_reg;
    perr_out_next = perr_out_reg;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_MID) begin
            s_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next = '0;
            b_next = {rx_s, b_reg[DBIT-1:1]};
            if (n_reg == N_LAST) state_next = DATA_EXIT;
            else                 n_next     = n_reg + 3'd1;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = '0;
            perr_next  = (^b_reg) ^ rx_s ^ PAR_ODD;
            state_next = STOP;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == S_STOP) begin
            state_next    = IDLE;
            s_next        = '0;
            done_next     = 1'b1;
            dout_next     = 8'(b_reg);
            ferr_next     = ~rx_s;
            perr_out_next = perr_reg & HAS_PARITY;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dout         = dout_reg;
  assign rx_done_tick = done_reg;
  assign frame_err    = ferr_reg;
  assign parity_err   = perr_out_reg;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed frames plus randomized traffic against a frame-level model.
module tb_uart_rx_os;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam bit PAR_ODD = 1'b0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  int checks     = 0;
  int errors     = 0;
  int done_count = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } frame_t;

  frame_t     exp_q[$];
  frame_t     cur;
  logic [7:0] m_dout;
  logic       m_ferr;
  logic       m_perr;

  uart_rx_os #(
    .DBIT   (DBIT),
    .SB_TICK(SB_TICK),
    .PAR_ODD(PAR_ODD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_tick      (s_tick),
    .rx          (rx),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  // One-clock baud tick every fourth clock, changed on the falling edge.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every cycle: outputs must hold the last delivered frame; a done pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_dout = 8'h00;
      m_ferr = 1'b0;
      m_perr = 1'b0;
      exp_q.delete();
      check_output("done_in_reset", rx_done_tick, 0);
    end else if (rx_done_tick === 1'b1) begin
      done_count++;
      check_output("done_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        cur    = exp_q.pop_front();
        m_dout = cur.data;
        m_ferr = cur.ferr;
        m_perr = cur.perr;
      end
    end
    check_output("dout", dout, m_dout);
    check_output("frame_err", frame_err, m_ferr);
    check_output("parity_err", parity_err, m_perr);
  end

  // Waits for n baud ticks, returning just after the clock edge of the last one.
  task automatic tick_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  // Sends one frame; a bad stop bit stays low 12 ticks so the line is high again before the restart check.
  task automatic apply_stimulus(input logic [7:0] data, input bit stop_ok, input bit par_flip, input int gap);
    frame_t f;
    f.data = data;
    f.ferr = !stop_ok;
    f.perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    f.perr = par_flip;
`endif
    exp_q.push_back(f);
    rx = 1'b0;
    tick_wait(16);
    for (int i = 0; i < DBIT; i++) begin
      rx = data[i];
      tick_wait(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^data) ^ PAR_ODD ^ par_flip;
    tick_wait(16);
`endif
    if (stop_ok) begin
      rx = 1'b1;
      tick_wait(16);
    end else begin
      rx = 1'b0;
      tick_wait(12);
      rx = 1'b1;
      tick_wait(4);
    end
    if (gap > 0) tick_wait(gap);
    check_output("frame_drained", exp_q.size(), 0);
  endtask

  task automatic glitch(input int low_ticks, input int idle_ticks);
    rx = 1'b0;
    tick_wait(low_ticks);
    rx = 1'b1;
    tick_wait(idle_ticks);
  endtask

  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_dout", dout, 8'h00);
    check_output("reset_done", rx_done_tick, 0);
    check_output("reset_ferr", frame_err, 0);
    check_output("reset_perr", parity_err, 0);
    reset_n = 1'b1;
    tick_wait(10);

    $display("[TB] frame 0xA5");
    apply_stimulus(8'hA5, 1'b1, 1'b0, 8);
    check_output("t1_dout", dout, 8'hA5);
    check_output("t1_ferr", frame_err, 0);
    check_output("t1_count", done_count, 1);

    $display("[TB] short low glitch");
    glitch(5, 16);
    check_output("t2_count", done_count, 1);
    check_output("t2_dout", dout, 8'hA5);

    $display("[TB] bad stop bit then clean frame");
    apply_stimulus(8'h3C, 1'b0, 1'b0, 8);
    check_output("t3_dout", dout, 8'h3C);
    check_output("t3_ferr", frame_err, 1);
    check_output("t3_count", done_count, 2);
    apply_stimulus(8'h3C, 1'b1, 1'b0, 8);
    check_output("t3_ferr_clear", frame_err, 0);

    $display("[TB] back-to-back frames");
    apply_stimulus(8'h00, 1'b1, 1'b0, 0);
    apply_stimulus(8'hFF, 1'b1, 1'b0, 0);
    apply_stimulus(8'h55, 1'b1, 1'b0, 8);
    check_output("t4_count", done_count, 6);
    check_output("t4_dout", dout, 8'h55);

    $display("[TB] reset mid-data");
    rx = 1'b0;
    tick_wait(16 + 16 * 3 + 5);
    reset_n = 1'b0;
    rx      = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick_wait(20);
    check_output("t5_dout", dout, 8'h00);
    check_output("t5_ferr", frame_err, 0);
    check_output("t5_count", done_count, 6);
    apply_stimulus(8'h81, 1'b1, 1'b0, 8);
    check_output("t5_dout_after", dout, 8'h81);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity check");
    apply_stimulus(8'h07, 1'b1, 1'b0, 8);
    check_output("t6_perr_good", parity_err, 0);
    apply_stimulus(8'h07, 1'b1, 1'b1, 8);
    check_output("t6_perr_bad", parity_err, 1);
`endif

    $display("[TB] randomized traffic");
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, 6), $urandom_range(10, 16));
      apply_stimulus(8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 12));
    end
    tick_wait(8);
    check_output("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
